// File: rtl/uart_rx_frame_if.sv
// Interface bundling the UART receiver serial input, frame configuration
// and the received-byte outputs that go to the register file / FIFO.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: oversampled start / 8 data (LSB first) / optional parity /
// stop, 2-of-3 majority per bit, single-cycle valid / error pulses.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_frame_if.slave bus
);
  localparam int BCW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic [PRESC_W-1:0]    r_presc;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [PRESC_W-1:0]    r_edge_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic [PRESC_W-1:0]    w_half;
  logic                  w_bit_end;
  logic                  w_eval;
  logic                  w_exp_par;
  logic                  w_par_bad;
  logic                  w_stp_bad;
  logic                  w_take;

  function automatic logic [PRESC_W-1:0] legal_presc(input logic [PRESC_W-1:0] p);
    case (p)
      PRESC_W'(8), PRESC_W'(16), PRESC_W'(32): return p;
      default:                                 return PRESC_W'(8);
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.RX_IN;
      r_rx_s  <= r_sync1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_half    = r_presc >> 1;
    w_bit_end = (r_edge_cnt == r_presc - PRESC_W'(1));
    w_eval    = (r_state == S_STOP) && (r_edge_cnt == w_half + PRESC_W'(2));
    w_exp_par = r_par_typ ? ~^r_shift : ^r_shift;
    w_par_bad = r_par_en && (r_par_bit != w_exp_par);
    w_stp_bad = ~r_bit;
    w_take    = w_eval && !w_par_bad && !w_stp_bad;
    case (r_state)
      S_IDLE:   if (!r_rx_s) w_next = S_START;
      S_START:  if (w_bit_end) w_next = r_bit ? S_IDLE : S_DATA;
      S_DATA:   if (w_bit_end && (r_bit_cnt == BCW'(DATA_WIDTH - 1)))
                  w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_eval) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc    <= PRESC_W'(8);
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_bit      <= 1'b1;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      r_valid   <= w_take;
      r_par_err <= w_eval && w_par_bad;
      r_stp_err <= w_eval && w_stp_bad;
      if (w_take) r_data <= r_shift;

      if (r_state == S_IDLE) begin
        // The cycle that sees rx_s low is edge 0 of the start bit, so START opens at 1.
        r_presc    <= legal_presc(bus.Prescale);
        r_par_en   <= bus.PAR_EN;
        r_par_typ  <= bus.PAR_TYP;
        r_edge_cnt <= PRESC_W'(1);
        r_bit_cnt  <= '0;
      end else begin
        r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + PRESC_W'(1);
        if (r_edge_cnt == w_half - PRESC_W'(1)) r_s0 <= r_rx_s;
        if (r_edge_cnt == w_half)               r_s1 <= r_rx_s;
        if (r_edge_cnt == w_half + PRESC_W'(1)) r_bit <= maj3(r_s0, r_s1, r_rx_s);
        if (r_state == S_DATA && w_bit_end) begin
          r_shift[r_bit_cnt] <= r_bit;
          r_bit_cnt          <= r_bit_cnt + BCW'(1);
        end
        if (r_state == S_PARITY && w_bit_end) r_par_bit <= r_bit;
      end
    end
  end

  assign bus.P_DATA     = r_data;
  assign bus.DATA_VALID = r_valid;
  assign bus.PAR_ERR    = r_par_err;
  assign bus.STP_ERR    = r_stp_err;
endmodule
